mplier_arbiter: RTL and testbench
=================================

# mplier_arbiter

Round-robin scheduler that shares one combinational `mplier8x8` signed 8x8 multiplier among `NREQ` requesters. Each requester offers an operand pair through a valid/ready handshake. The block registers the granted operands, multiplies them, registers the 16-bit product, and returns it tagged with the requester id on a single shared response channel. It sits between the client blocks and the multiplier datapath, accepts one operation per cycle at full throughput, and supports back-pressure on the response side.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `IDW`, 2, requester-id width, equal to clog2(`NREQ`)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `req_valid`  in  NREQ  per-requester operand valid
- `req_ready`  out  NREQ  per-requester accept; at most one bit set
- `req_a`  in  8*NREQ  packed signed operand A; requester i at [8i+7:8i]
- `req_b`  in  8*NREQ  packed signed operand B; same packing
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  IDW  requester index that owns the response
- `rsp_product`  out  16  signed product, two's complement
- `busy`  out  1  either pipeline stage holds an operation

## Operation
- Two pipeline stages, each with its own valid bit:
  - S1 (operand register): `s1_v`, `s1_a`, `s1_b`, `s1_id`.
  - S2 (result register): `s2_v`, `s2_prod`, `s2_id`. S2 drives the `rsp_*` outputs directly.
- Multiplier placement: `mplier8x8` sits combinationally between S1 and S2. Its port order is product, a, b.
- Stall rules:
  - `s2_adv = !s2_v | rsp_ready`
  - `s1_adv = !s1_v | s2_adv`
- When `s2_adv` is high, S2 loads S1 contents: `s2_v <= s1_v`. Otherwise S2 holds.
- Grant selection:
  - Only when `s1_adv` is high, the arbiter picks the first requester with `req_valid` set.
  - Search order starts at `ptr+1` and wraps modulo `NREQ`.
  - The chosen requester gets `req_ready[i]=1`.
  - If no requester is valid, or `s1_adv` is low, `req_ready` is all-zero.
- `req_ready` is combinational from `req_valid`, `ptr` and the stage state. Requesters must not make `req_valid` depend on `req_ready`.
- Acceptance is `req_valid[i] & req_ready[i]`. On acceptance:
  - S1 loads the operands and id, and sets `s1_v=1`.
  - `ptr <= i`.
- If `s1_adv` is high and nothing is accepted, `s1_v <= 0`.
- `ptr` changes only on acceptance.
- Arithmetic: full signed 8x8 to 16-bit, no saturation. -128*-128 = 16384 is representable.
- `busy = s1_v | s2_v`.
- Reset (`rst` high at a clock edge):
  - `s1_v`, `s2_v` = 0; `rsp_id` = 0; `rsp_product` = 0; `ptr` = NREQ-1, so the first grant goes to requester 0.
  - While `rst` is high, `req_ready` is forced to 0.
  - In-flight operations are dropped and never responded to. Reset mid-operation is legal at any cycle.
- Response ordering: responses leave in acceptance order. Each accepted operation produces exactly one response.

## Timing
- Latency: an operation accepted at edge N presents `rsp_valid=1` after edge N+1, i.e. it is visible in cycle N+1 when S2 is free.
- Throughput: one accept per cycle while `rsp_ready=1`.
- Response stability: while `rsp_valid & !rsp_ready`, `rsp_id` and `rsp_product` are held stable.
- Capacity: at most 2 operations are in flight. With `rsp_ready` low, at most 2 accepts occur, then `req_ready` stays 0.
- Simultaneous `rsp_ready` and acceptance in the same cycle: S2 loads from S1 and S1 loads the new operands. No bubble occurs.
- Fairness: a requester that keeps `req_valid` high is granted within `NREQ` accept slots.

## Structure
- Shared package `mplier_pkg` holds:
  - `OPW=8`, `PRODW=16`, the default `NREQ`.
  - Typedefs for the operand and product types.
- Sub-module `rr_arbiter`: purely combinational. Its inputs are the request vector, `ptr` and enable. Its outputs are a one-hot grant and the encoded index.
- `mplier_arbiter` contains:
  - the S1/S2 registers;
  - the `ptr` register;
  - one `rr_arbiter` instance;
  - one `mplier8x8` instance.

## Test plan
- Reset:
  - Stimulus: `rst`=1 for 2 cycles with all `req_valid`=1.
  - Required: `req_ready`=0, `rsp_valid`=0, `busy`=0 throughout. In the first cycle after release, `req_ready`=4'b0001.
- Single operation:
  - Stimulus: requester 2 with a=-3, b=7, accepted at edge N.
  - Required: `rsp_valid`=1 after edge N+1, `rsp_id`=2, `rsp_product`=16'hFFEB (-21).
- Round robin:
  - Stimulus: all 4 requesters valid continuously, `rsp_ready`=1.
  - Required: grants 0,1,2,3,0,1 on consecutive cycles, one response per cycle, ids matching that order.
- Back-pressure:
  - Stimulus: `rsp_ready`=0 for 5 cycles while requests are pending.
  - Required: exactly 2 accepts, then `req_ready`=0. `rsp_*` held stable. After release, responses arrive in order with none lost or duplicated.
- Corner products:
  - -128*-128 -> 16384
  - -128*127 -> -16256
  - 127*127 -> 16129
  - 0*-55 -> 0
  - -1*-1 -> 1
- Reset mid-operation:
  - Stimulus: S1 and S2 full, `rsp_ready`=0, then `rst` high for 1 cycle.
  - Required: next cycle `rsp_valid`=0 and `busy`=0. The first grant after release goes to requester 0.

Source files
------------

// File: rtl/mplier_pkg.sv
// Shared widths and types for the shared-multiplier arbiter.
package mplier_pkg;
  localparam int OPW      = 8;
  localparam int PRODW    = 16;
  localparam int NREQ_DEF = 4;

  typedef logic signed [OPW-1:0]   opnd_t;
  typedef logic signed [PRODW-1:0] prod_t;
endpackage

// File: rtl/mplier_arbiter_if.sv
// Requester and response bundle between clients and the multiplier arbiter.
interface mplier_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_product;
  logic              busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product, busy
  );
endinterface

// File: rtl/mplier8x8.sv
// Combinational signed 8x8 -> 16 multiplier.
module mplier8x8
  import mplier_pkg::*;
(
  output prod_t prod_o,
  input  opnd_t a_i,
  input  opnd_t b_i
);
  assign prod_o = a_i * b_i;
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick, searching from ptr+1 with wrap.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  input  logic           en_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o
);
  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (en_i && !found && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = IDW'(j);
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mplier_arbiter.sv
// Round-robin sharing of one signed 8x8 multiplier; two-stage
// operand/result pipeline with response back-pressure.
module mplier_arbiter
  import mplier_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic clk,
  input logic rst,
  mplier_arbiter_if.slave bus
);
  logic           s1_v_q, s1_v_d;
  opnd_t          s1_a_q, s1_a_d;
  opnd_t          s1_b_q, s1_b_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic           s2_v_q, s2_v_d;
  prod_t          s2_prod_q, s2_prod_d;
  logic [IDW-1:0] s2_id_q, s2_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  prod_t           mul_p;
  logic            s1_adv, s2_adv, acc;

  assign s2_adv = !s2_v_q || bus.rsp_ready;
  assign s1_adv = !s1_v_q || s2_adv;
  assign acc    = |gnt;

  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .en_i  (s1_adv && !rst),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  mplier8x8 u_mul (
    .prod_o (mul_p),
    .a_i    (s1_a_q),
    .b_i    (s1_b_q)
  );

  always_comb begin
    s2_v_d    = s2_v_q;
    s2_prod_d = s2_prod_q;
    s2_id_d   = s2_id_q;
    if (s2_adv) begin
      s2_v_d    = s1_v_q;
      s2_prod_d = mul_p;
      s2_id_d   = s1_id_q;
    end
  end

  always_comb begin
    s1_v_d  = s1_v_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s1_id_d = s1_id_q;
    ptr_d   = ptr_q;
    if (acc) begin
      s1_v_d  = 1'b1;
      s1_a_d  = bus.req_a[OPW*gidx +: OPW];
      s1_b_d  = bus.req_b[OPW*gidx +: OPW];
      s1_id_d = gidx;
      ptr_d   = gidx;
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_id_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_prod_q <= '0;
      s2_id_q   <= '0;
      ptr_q     <= IDW'(NREQ - 1);
    end else begin
      s1_v_q    <= s1_v_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_id_q   <= s1_id_d;
      s2_v_q    <= s2_v_d;
      s2_prod_q <= s2_prod_d;
      s2_id_q   <= s2_id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.req_ready   = gnt;
  assign bus.rsp_valid   = s2_v_q;
  assign bus.rsp_id      = s2_id_q;
  assign bus.rsp_product = s2_prod_q;
  assign bus.busy        = s1_v_q || s2_v_q;
endmodule

// File: tb/tb_mplier_arbiter.sv
// Randomized and directed check of mplier_arbiter against a queue model.
module tb_mplier_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mplier_arbiter_if #(.NREQ(N), .IDW(2)) bus ();

  mplier_arbiter #(.NREQ(N), .IDW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          id;
    logic [15:0] prod;
    int          stamp;
  } item_t;

  item_t q[$];
  int    ptr = N - 1;
  int    edges = 0;
  int    checks = 0;
  int    errors = 0;
  logic  last_rst = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (edge %0d)", tag, got, exp, edges);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a,
                                          input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  task automatic step(input logic r, input logic [N-1:0] rv,
                      input logic [8*N-1:0] a, input logic [8*N-1:0] b,
                      input logic rr);
    int   g;
    int   jj;
    logic vis;
    @(negedge clk);
    rst           = r;
    bus.req_valid = rv;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = rr;
    #1;
    g = -1;
    if (!r && (q.size() < 2 || rr))
      for (int k = 1; k <= N; k++) begin
        jj = (ptr + k) % N;
        if (g < 0 && rv[jj]) g = jj;
      end
    chk("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    vis = (q.size() > 0) && (q[0].stamp < edges);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(vis));
    chk("busy", 32'(bus.busy), 32'(q.size() > 0));
    if (vis) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
      chk("rsp_product", 32'(bus.rsp_product), 32'(q[0].prod));
    end else if (last_rst) begin
      chk("rst_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_product", 32'(bus.rsp_product), 32'd0);
    end
    if (r) begin
      q.delete();
      ptr = N - 1;
    end else begin
      if (vis && rr) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back('{g, ref_mul(a[8*g +: 8], b[8*g +: 8]), edges + 1});
        ptr = g;
      end
    end
    last_rst = r;
    edges++;
  endtask

  logic [7:0] ca[5] = '{8'h80, 8'h80, 8'h7F, 8'h00, 8'hFF};
  logic [7:0] cb[5] = '{8'h80, 8'h7F, 8'h7F, 8'hC9, 8'hFF};

  initial begin
    logic [8*N-1:0] va, vb;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);

    // reset with all requesters valid
    step(1, 4'hF, 32'h0403_0201, 32'h0101_0101, 1);
    step(1, 4'hF, 32'h0403_0201, 32'h0101_0101, 1);
    step(0, 4'hF, 32'h0403_0201, 32'h0101_0101, 1);
    repeat (3) step(0, 4'h0, '0, '0, 1);

    // single op: requester 2, -3 * 7
    step(0, 4'b0100, 32'h00FD_0000, 32'h0007_0000, 1);
    repeat (2) step(0, 4'h0, '0, '0, 1);

    // corner products
    for (int i = 0; i < 5; i++) begin
      va = '0;
      vb = '0;
      va[8*(i%N) +: 8] = ca[i];
      vb[8*(i%N) +: 8] = cb[i];
      step(0, 4'(1 << (i % N)), va, vb, 1);
    end
    repeat (2) step(0, 4'h0, '0, '0, 1);

    // round robin at full rate
    for (int i = 0; i < 6; i++)
      step(0, 4'hF, $urandom, $urandom, 1);

    // back-pressure then drain
    for (int i = 0; i < 5; i++)
      step(0, 4'hF, $urandom, $urandom, 0);
    repeat (4) step(0, 4'h0, '0, '0, 1);

    // reset with both stages full
    repeat (3) step(0, 4'hF, $urandom, $urandom, 0);
    step(1, 4'hF, $urandom, $urandom, 0);
    step(0, 4'hF, $urandom, $urandom, 1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 59) == 0), 4'($urandom),
           $urandom, $urandom, ($urandom_range(0, 3) != 0));
    repeat (4) step(0, 4'h0, '0, '0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
